// File: rtl/lm80c_mem_pkg.sv
// Shared types and region map for the LM80C memory arbiter.
// The ROM/RAM windows are expressed in loader byte-address space.
package lm80c_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CPU_RA = 3'd1,
        ST_CPU_RD = 3'd2,
        ST_CPU_WR = 3'd3,
        ST_LD_WR  = 3'd4
    } state_t;

    localparam logic [31:0] ROM_END  = 32'h0000_8000;
    localparam logic [31:0] RAM_BASE = 32'h0001_0000;
    localparam logic [31:0] RAM_END  = 32'h0002_0000;

    typedef struct packed {
        logic        is_rom;
        logic [15:0] addr;
        logic [7:0]  data;
    } ld_entry_t;

    // Result bit 1: address lands in a memory window; bit 0: that window is the ROM.
    function automatic logic [1:0] ld_region(input logic [31:0] addr);
        logic is_rom;
        logic is_ram;
        is_rom = (addr < ROM_END);
        is_ram = (addr >= RAM_BASE) && (addr < RAM_END);
        return {is_rom | is_ram, is_rom};
    endfunction

endpackage

// File: rtl/lm80c_wr_fifo.sv
// Small synchronous FIFO that buffers decoded loader writes.
// Storage is not reset; the pointers and level define which entries are live.
module lm80c_wr_fifo
    import lm80c_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  ld_entry_t                     push_data,
    input  logic                          pop,
    output ld_entry_t                     head,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    ld_entry_t       r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign full      = (r_level == LW'(FIFO_DEPTH));
    assign empty     = (r_level == LW'(0));
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign head      = r_mem[r_rd_ptr];
    assign level     = r_level;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/lm80c_mem_arbiter.sv
// Arbitrates Z80 and loader accesses onto the ROM and RAM dpram ports.
// CPU requests always win; queued loader writes drain in idle cycles.
module lm80c_mem_arbiter
    import lm80c_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LD_AW      = 25
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cpu_ena,
    input  logic                          cpu_rd,
    input  logic                          cpu_wr,
    input  logic [15:0]                   cpu_addr,
    input  logic [7:0]                    cpu_wdata,
    input  logic                          rom_enabled,
    output logic [7:0]                    cpu_rdata,
    output logic                          cpu_wait,
    input  logic                          ld_hold,
    input  logic                          ld_valid,
    input  logic [LD_AW-1:0]              ld_addr,
    input  logic [7:0]                    ld_data,
    output logic                          ld_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [14:0]                   rom_addr,
    output logic                          rom_we,
    output logic [7:0]                    rom_wdata,
    input  logic [7:0]                    rom_q,
    output logic [15:0]                   ram_addr,
    output logic                          ram_we,
    output logic [7:0]                    ram_wdata,
    input  logic [7:0]                    ram_q
);

    state_t      r_state, w_state_nxt;
    logic        r_pend_valid, r_pend_rd;
    logic [15:0] r_pend_addr;
    logic [7:0]  r_pend_data;
    logic        r_rd_rom, w_rd_rom_nxt;
    logic [14:0] r_rom_addr, w_rom_addr_nxt;
    logic        r_rom_we, w_rom_we_nxt;
    logic [7:0]  r_rom_wdata, w_rom_wdata_nxt;
    logic [15:0] r_ram_addr, w_ram_addr_nxt;
    logic        r_ram_we, w_ram_we_nxt;
    logic [7:0]  r_ram_wdata, w_ram_wdata_nxt;
    logic [7:0]  r_cpu_rdata, w_cpu_rdata_nxt;
    logic        w_cap, w_pend_clr, w_req_valid, w_req_rd, w_rom_sel;
    logic [15:0] w_req_addr;
    logic [7:0]  w_req_data;
    logic [31:0] w_ld_addr32;
    logic [1:0]  w_ld_region;
    logic        w_push, w_pop, w_full, w_empty;
    ld_entry_t   w_push_entry, w_head;

    assign w_cap       = cpu_ena & (cpu_rd | cpu_wr) & ~ld_hold;
    assign w_ld_addr32 = 32'(ld_addr);
    assign w_ld_region = ld_region(w_ld_addr32);
    assign ld_ready    = ~w_full;
    assign w_push      = ld_valid & ~w_full & w_ld_region[1];
    assign w_pop       = (r_state == ST_LD_WR);
    assign cpu_wait    = ld_hold;

    always_comb begin
        w_push_entry        = '0;
        w_push_entry.is_rom = w_ld_region[0];
        w_push_entry.data   = ld_data;
        if (w_ld_region[0]) begin
            w_push_entry.addr = {1'b0, w_ld_addr32[14:0]};
        end else begin
            w_push_entry.addr = w_ld_addr32[15:0];
        end
    end

    lm80c_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head),
        .level     (fifo_level),
        .full      (w_full),
        .empty     (w_empty)
    );

    // A capture in IDLE is served straight from the bus so the address is out next cycle.
    always_comb begin
        if (r_pend_valid) begin
            w_req_rd   = r_pend_rd;
            w_req_addr = r_pend_addr;
            w_req_data = r_pend_data;
        end else begin
            w_req_rd   = cpu_rd;
            w_req_addr = cpu_addr;
            w_req_data = cpu_wdata;
        end
        w_req_valid = r_pend_valid | w_cap;
        w_rom_sel   = rom_enabled & ~w_req_addr[15];
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rd_rom_nxt    = r_rd_rom;
        w_rom_addr_nxt  = r_rom_addr;
        w_rom_we_nxt    = 1'b0;
        w_rom_wdata_nxt = r_rom_wdata;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_we_nxt    = 1'b0;
        w_ram_wdata_nxt = r_ram_wdata;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_pend_clr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_valid && w_req_rd) begin
                    w_state_nxt  = ST_CPU_RA;
                    w_rd_rom_nxt = w_rom_sel;
                    if (w_rom_sel) begin
                        w_rom_addr_nxt = w_req_addr[14:0];
                    end else begin
                        w_ram_addr_nxt = w_req_addr;
                    end
                end else if (w_req_valid) begin
                    // Writes into the mapped ROM window still pass through CPU_WR, without a strobe.
                    w_state_nxt = ST_CPU_WR;
                    if (!w_rom_sel) begin
                        w_ram_we_nxt    = 1'b1;
                        w_ram_addr_nxt  = w_req_addr;
                        w_ram_wdata_nxt = w_req_data;
                    end else begin
                        w_ram_we_nxt = 1'b0;
                    end
                end else if (!w_empty) begin
                    w_state_nxt = ST_LD_WR;
                    if (w_head.is_rom) begin
                        w_rom_we_nxt    = 1'b1;
                        w_rom_addr_nxt  = w_head.addr[14:0];
                        w_rom_wdata_nxt = w_head.data;
                    end else begin
                        w_ram_we_nxt    = 1'b1;
                        w_ram_addr_nxt  = w_head.addr;
                        w_ram_wdata_nxt = w_head.data;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CPU_RA: w_state_nxt = ST_CPU_RD;
            ST_CPU_RD: begin
                w_cpu_rdata_nxt = r_rd_rom ? rom_q : ram_q;
                w_pend_clr      = 1'b1;
                w_state_nxt     = ST_IDLE;
            end
            ST_CPU_WR: begin
                w_pend_clr  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_LD_WR:  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_rd    <= 1'b0;
            r_pend_addr  <= 16'h0000;
            r_pend_data  <= 8'h00;
        end else if (w_cap) begin
            r_pend_valid <= 1'b1;
            r_pend_rd    <= cpu_rd;
            r_pend_addr  <= cpu_addr;
            r_pend_data  <= cpu_wdata;
        end else if (w_pend_clr) begin
            r_pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rd_rom    <= 1'b0;
            r_rom_addr  <= 15'h0000;
            r_rom_we    <= 1'b0;
            r_rom_wdata <= 8'h00;
            r_ram_addr  <= 16'h0000;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= 8'h00;
            r_cpu_rdata <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_rom    <= w_rd_rom_nxt;
            r_rom_addr  <= w_rom_addr_nxt;
            r_rom_we    <= w_rom_we_nxt;
            r_rom_wdata <= w_rom_wdata_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign rom_we    = r_rom_we;
    assign rom_wdata = r_rom_wdata;
    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_wdata = r_ram_wdata;
    assign cpu_rdata = r_cpu_rdata;

endmodule

// File: tb/tb_lm80c_mem_arbiter.sv
// Directed bench for lm80c_mem_arbiter with behavioural ROM/RAM dprams.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lm80c_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset, cpu_ena, cpu_rd, cpu_wr, rom_enabled, ld_hold, ld_valid;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata, ld_data, rom_wdata, ram_wdata;
    logic        cpu_wait, ld_ready, rom_we, ram_we;
    logic [24:0] ld_addr;
    logic [2:0]  fifo_level;
    logic [14:0] rom_addr;
    logic [15:0] ram_addr;
    logic [7:0]  rom_q = 8'h00;
    logic [7:0]  ram_q = 8'h00;

    logic [7:0]  rom_mem [32768];
    logic [7:0]  ram_mem [65536];

    int n_tests = 0;
    int n_fail  = 0;
    int n_rom_we = 0, n_ram_we = 0, n_both_we = 0, n_cpu_wr = 0;
    logic [15:0] ld_log_addr [$];
    logic [7:0]  ld_log_data [$];
    int          ld_log_seen [$];
    int          push_seen [6];

    always #5 clk = ~clk;

    lm80c_mem_arbiter #(.FIFO_DEPTH(4), .LD_AW(25)) dut (
        .clk(clk), .reset(reset), .cpu_ena(cpu_ena), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .rom_enabled(rom_enabled),
        .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait), .ld_hold(ld_hold), .ld_valid(ld_valid),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready), .fifo_level(fifo_level),
        .rom_addr(rom_addr), .rom_we(rom_we), .rom_wdata(rom_wdata), .rom_q(rom_q),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q)
    );

    initial begin
        for (int i = 0; i < 32768; i++) rom_mem[i] = 8'h00;
        for (int i = 0; i < 65536; i++) ram_mem[i] = 8'h00;
        rom_mem[16'h0010] = 8'hA5;
        rom_mem[16'h0020] = 8'h77;
        ram_mem[16'h0010] = 8'h3C;
    end

    always @(posedge clk) begin
        rom_q <= rom_mem[rom_addr];
        ram_q <= ram_mem[ram_addr];
        if (rom_we) rom_mem[rom_addr] <= rom_wdata;
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    end

    always @(posedge clk) begin
        if (rom_we) n_rom_we <= n_rom_we + 1;
        if (ram_we) n_ram_we <= n_ram_we + 1;
        if (rom_we && ram_we) n_both_we <= n_both_we + 1;
        if (ram_we && ram_addr >= 16'h2000) n_cpu_wr <= n_cpu_wr + 1;
        if (ram_we && ram_addr < 16'h0100) begin
            ld_log_addr.push_back(ram_addr);
            ld_log_data.push_back(ram_wdata);
            ld_log_seen.push_back(n_cpu_wr);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int r0, w0, cpu0, ncap, idx, cyc, saw4, bad_ready, waitc;
        reset = 1'b1; cpu_ena = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; rom_enabled = 1'b0;
        ld_hold = 1'b0; ld_valid = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        ld_addr = 25'h0; ld_data = 8'h00;
        repeat (3) step();
        check("rst_rom_we", rom_we, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_ld_ready", ld_ready, 1'b1);
        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_wait", cpu_wait, 1'b0);
        reset = 1'b0;
        step();

        // ROM read: address at T+1, dpram data at T+2, cpu_rdata at T+3
        w0 = n_ram_we;
        rom_enabled = 1'b1; cpu_addr = 16'h0010; cpu_rd = 1'b1; cpu_ena = 1'b1;
        step(); cpu_ena = 1'b0; cpu_rd = 1'b0;
        check("rd_rom_addr_t1", rom_addr, 15'h0010);
        step();
        check("rd_rom_q_t2", rom_q, 8'hA5);
        step();
        check("rd_rdata_t3", cpu_rdata, 8'hA5);
        step();
        check("rd_no_ram_we", n_ram_we, w0);
        repeat (3) step();

        // Write into mapped ROM is dropped
        r0 = n_rom_we; w0 = n_ram_we;
        cpu_addr = 16'h1234; cpu_wdata = 8'h5A; cpu_wr = 1'b1; cpu_ena = 1'b1;
        step(); cpu_ena = 1'b0; cpu_wr = 1'b0;
        repeat (5) step();
        check("wp_rom_we", n_rom_we, r0);
        check("wp_ram_we", n_ram_we, w0);

        // ROM mapped out: same write lands in RAM
        rom_enabled = 1'b0; cpu_wr = 1'b1; cpu_ena = 1'b1;
        step(); cpu_ena = 1'b0; cpu_wr = 1'b0;
        check("mo_ram_we", ram_we, 1'b1);
        check("mo_ram_addr", ram_addr, 16'h1234);
        check("mo_ram_wdata", ram_wdata, 8'h5A);
        step();
        check("mo_ram_we_off", ram_we, 1'b0);
        check("mo_ram_mem", ram_mem[16'h1234], 8'h5A);
        repeat (4) step();
        check("mo_one_write", n_ram_we, w0 + 1);

        // Loader write into ROM window
        ld_valid = 1'b1; ld_addr = 25'h0000100; ld_data = 8'h11;
        step(); ld_valid = 1'b0;
        check("ldr_level1", fifo_level, 3'd1);
        step();
        check("ldr_rom_we", rom_we, 1'b1);
        check("ldr_rom_addr", rom_addr, 15'h0100);
        check("ldr_rom_wdata", rom_wdata, 8'h11);
        check("ldr_no_ram_we", ram_we, 1'b0);
        step();
        check("ldr_rom_we_off", rom_we, 1'b0);
        check("ldr_level0", fifo_level, 3'd0);

        // Loader address in the hole is accepted and discarded
        r0 = n_rom_we; w0 = n_ram_we;
        ld_valid = 1'b1; ld_addr = 25'h0009000; ld_data = 8'h22;
        check("disc_ready", ld_ready, 1'b1);
        step(); ld_valid = 1'b0;
        check("disc_level", fifo_level, 3'd0);
        repeat (4) step();
        check("disc_rom_we", n_rom_we, r0);
        check("disc_ram_we", n_ram_we, w0);

        // Hold blocks capture; cpu_rdata keeps the earlier ROM byte
        ld_hold = 1'b1; rom_enabled = 1'b1; cpu_addr = 16'h0020; cpu_rd = 1'b1; cpu_ena = 1'b1;
        #1;
        check("hold_wait", cpu_wait, 1'b1);
        step(); cpu_ena = 1'b0; cpu_rd = 1'b0;
        repeat (4) step();
        check("hold_rdata", cpu_rdata, 8'hA5);
        ld_hold = 1'b0;
        #1;
        check("hold_wait_off", cpu_wait, 1'b0);
        step();

        // Loader burst with back-pressure and interleaved CPU writes
        rom_enabled = 1'b0;
        ld_log_addr.delete(); ld_log_data.delete(); ld_log_seen.delete();
        cpu0 = n_cpu_wr; ncap = 0; idx = 0; cyc = 0; saw4 = 0; bad_ready = 0;
        while ((idx < 6 || ncap < 3) && cyc < 100) begin
            if (cyc % 6 == 0 && ncap < 3) begin
                cpu_ena = 1'b1; cpu_wr = 1'b1;
                cpu_addr = 16'h2000 + 16'(ncap); cpu_wdata = 8'h80 + 8'(ncap);
                ncap++;
            end else begin
                cpu_ena = 1'b0; cpu_wr = 1'b0;
            end
            if (fifo_level == 3'd4) begin
                saw4++;
                if (ld_ready !== 1'b0) bad_ready++;
            end
            if (idx < 6) begin
                ld_valid = 1'b1; ld_addr = 25'h0010005 + 25'(idx); ld_data = 8'h40 + 8'(idx);
                if (ld_ready) begin
                    push_seen[idx] = ncap;
                    idx++;
                end
            end else begin
                ld_valid = 1'b0;
            end
            step();
            cyc++;
        end
        ld_valid = 1'b0; cpu_ena = 1'b0; cpu_wr = 1'b0;
        waitc = 0;
        while ((ld_log_addr.size() < 6 || n_cpu_wr < cpu0 + 3) && waitc < 200) begin
            step();
            waitc++;
        end
        check("burst_ld_count", ld_log_addr.size(), 6);
        check("burst_cpu_count", n_cpu_wr - cpu0, 3);
        check("burst_saw_level4", (saw4 > 0), 1'b1);
        check("burst_ready_at_4", bad_ready, 0);
        for (int i = 0; i < 6; i++) begin
            if (i < ld_log_addr.size()) begin
                check("burst_addr", ld_log_addr[i], 16'h0005 + 16'(i));
                check("burst_data", ld_log_data[i], 8'h40 + 8'(i));
                check("burst_order", (ld_log_seen[i] - cpu0 >= push_seen[i]), 1'b1);
            end
        end
        for (int k = 0; k < 3; k++) begin
            check("burst_cpu_mem", ram_mem[16'h2000 + 16'(k)], 8'h80 + 8'(k));
        end
        check("never_both_we", n_both_we, 0);

        // Reset during a loader write flushes the FIFO and clears outputs
        ld_valid = 1'b1; ld_addr = 25'h0010040; ld_data = 8'hE1;
        step();
        ld_addr = 25'h0010041; ld_data = 8'hE2;
        step();
        ld_valid = 1'b0;
        waitc = 0;
        while (ram_we !== 1'b1 && waitc < 20) begin
            step();
            waitc++;
        end
        check("rst2_ldwr_seen", ram_we, 1'b1);
        reset = 1'b1;
        repeat (3) step();
        check("rst2_rom_we", rom_we, 1'b0);
        check("rst2_ram_we", ram_we, 1'b0);
        check("rst2_level", fifo_level, 3'd0);
        check("rst2_ld_ready", ld_ready, 1'b1);
        check("rst2_rdata", cpu_rdata, 8'h00);
        reset = 1'b0;
        repeat (6) step();
        check("rst2_flushed", ram_mem[16'h0041], 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lm80c_mem_arbiter.md
Name: lm80c_mem_arbiter

Overview:
Sequences all accesses to the on-chip 32 KB ROM and 64 KB RAM. There are two requesters:
- the Z80 side, one access per cpu_ena slot;
- the loader side (downloader/eraser write stream), buffered in a small write FIFO.

The block decodes regions and applies ROM write protection. It returns registered read data to the CPU and drains loader writes in cycles the CPU leaves idle. It sits between lm80c/downloader/eraser and the two dpram instances.

Parameters:
FIFO_DEPTH, 4, loader write FIFO entries (power of 2, >=2)
LD_AW, 25, loader address width

Ports:
clk  in  1  system clock (clk_sys domain)
reset  in  1  synchronous, active-high reset
cpu_ena  in  1  Z80 clock-enable strobe (1 clk wide, period >=6 clk)
cpu_rd  in  1  CPU read request, sampled on cpu_ena
cpu_wr  in  1  CPU write request, sampled on cpu_ena
cpu_addr  in  16  CPU address
cpu_wdata  in  8  CPU write data
rom_enabled  in  1  PIO B bit0; ROM mapped at 0x0000-0x7FFF
cpu_rdata  out  8  registered read data
cpu_wait  out  1  CPU hold (= ld_hold)
ld_hold  in  1  downloader/eraser active
ld_valid  in  1  loader write valid
ld_addr  in  LD_AW  loader byte address
ld_data  in  8  loader byte
ld_ready  out  1  FIFO can accept
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
rom_addr  out  15  ROM port address
rom_we  out  1  ROM write enable
rom_wdata  out  8  ROM write data
rom_q  in  8  ROM read data (1-clk registered dpram)
ram_addr  out  16  RAM port address
ram_we  out  1  RAM write enable
ram_wdata  out  8  RAM write data
ram_q  in  8  RAM read data (1-clk registered dpram)

Behaviour:
- Reset values:
  - all outputs 0, except ld_ready = 1;
  - FIFO flushed, state IDLE, pending request cleared;
  - reset mid-access aborts the access with no write.
- Loader decode at FIFO push:
  - addr < 0x08000 → ROM, offset [14:0];
  - 0x10000 ≤ addr < 0x20000 → RAM, offset [15:0];
  - any other address is accepted and discarded (not queued).
- FIFO behaviour:
  - ld_ready = (fifo_level < FIFO_DEPTH), from registered level;
  - a push and a pop in the same cycle keep the level unchanged;
  - ld_valid while ld_ready = 0 is ignored (loader must hold).
- CPU capture happens on a cpu_ena cycle with (cpu_rd | cpu_wr) and ld_hold = 0.
  - A capture latches addr, data and type into the pending register.
  - If both rd and wr are set, the request is treated as a read.
- CPU decode:
  - rom_sel = rom_enabled & addr < 0x8000;
  - a read with rom_sel reads the ROM, otherwise the RAM;
  - a write with rom_sel is dropped (no we);
  - any other write goes to RAM (full 64 KB when rom_enabled = 0).
- FSM states: IDLE, CPU_RA, CPU_RD, CPU_WR, LD_WR.
  - IDLE: if pending CPU → CPU_RA (read) or CPU_WR (write); else if FIFO non-empty → LD_WR; else stay.
  - CPU_RA: drive rom_addr/ram_addr → CPU_RD.
  - CPU_RD: capture rom_q or ram_q into cpu_rdata; clear pending → IDLE.
  - CPU_WR: one-cycle ram_we with addr/data; clear pending → IDLE.
  - LD_WR: one-cycle rom_we or ram_we from FIFO head; pop → IDLE.
- Priority: a pending CPU request always wins in IDLE. A capture that arrives during LD_WR is served next. At most one loader write per gap.
- Latency: cpu_ena capture at cycle T (IDLE) gives cpu_rdata valid after edge T+3, and it holds until the next read completes.
- Write-enable rule: we is asserted only in the CPU_WR and LD_WR states, and never on both memories at once.

Decomposition:
- Package lm80c_mem_pkg holds:
  - state enum;
  - region constants ROM_END = 0x08000, RAM_BASE = 0x10000, RAM_END = 0x20000;
  - FIFO entry struct {is_rom, addr[15:0], data[7:0]}.
- Sub-module lm80c_wr_fifo: synchronous FIFO with push/pop/level/full/empty, parameter FIFO_DEPTH.

Test Plan:
- Reset: hold reset 3 clk during an active LD_WR → all we = 0, fifo_level = 0, ld_ready = 1, cpu_rdata = 0x00.
- ROM read: rom_enabled = 1, cpu_rd, cpu_addr = 0x0010, rom_q = 0xA5 at T+2 → rom_addr = 0x0010 at T+1, cpu_rdata = 0xA5 at T+3, ram_we never set.
- Write protect and map-out:
  - rom_enabled = 1, cpu_wr to 0x1234 with data 0x5A → no rom_we or ram_we;
  - rom_enabled = 0, same write → ram_we one clk, ram_addr = 0x1234, ram_wdata = 0x5A.
- Loader burst with back-pressure:
  - 6 back-to-back ld_valid at 0x10005.. while a CPU write is pending each slot;
  - ld_ready drops at level 4;
  - all 6 bytes reach ram_addr 0x0005..0x000A in order;
  - CPU write completes before any loader write queued after it.
- Loader decode: ld_addr = 0x00100 data 0x11 → rom_we, rom_addr = 0x0100; ld_addr = 0x09000 → accepted, no write, level unchanged.
- Hold: ld_hold = 1 with cpu_ena + cpu_rd → cpu_wait = 1, no capture, cpu_rdata unchanged.
